// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes, signs applied at the end.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } stateType;

    stateType         stateReg, stateNext;
    logic [CW-1:0]    cntReg, cntNext;
    logic [WIDTH-1:0] hiReg, hiNext;
    logic [WIDTH-1:0] loReg, loNext;
    logic [WIDTH-1:0] accHiReg, accHiNext;
    logic [WIDTH-1:0] accLoReg, accLoNext;
    logic [WIDTH-1:0] magBReg, magBNext;
    logic             isDivReg, isDivNext;
    logic             negQuotReg, negQuotNext;
    logic             negRemReg, negRemNext;
    logic             zeroDivReg, zeroDivNext;
    logic             doneReg, doneNext;
    logic             dzReg, dzNext;

    // Operand magnitudes and result signs, sampled on the start edge
    logic             signedOp;
    logic [WIDTH-1:0] magA, magB;

    assign signedOp = Op[0];
    assign magA     = (signedOp && OperandA[WIDTH-1]) ? -OperandA : OperandA;
    assign magB     = (signedOp && OperandB[WIDTH-1]) ? -OperandB : OperandB;

    // Multiply step: add multiplicand when the low product bit is set, then shift right
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHi, mulLo;

    assign mulSum = {1'b0, accHiReg} + ({(WIDTH+1){accLoReg[0]}} & {1'b0, magBReg});
    assign mulHi  = mulSum[WIDTH:1];
    assign mulLo  = {mulSum[0], accLoReg[WIDTH-1:1]};

    // Restoring divide step: shift next dividend bit into the remainder, keep it if subtraction fits
    logic [WIDTH:0]   divShift, divTrial;
    logic [WIDTH-1:0] divHi, divLo;

    assign divShift = {accHiReg, accLoReg[WIDTH-1]};
    assign divTrial = divShift - {1'b0, magBReg};
    assign divHi    = divTrial[WIDTH] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
    assign divLo    = {accLoReg[WIDTH-2:0], ~divTrial[WIDTH]};

    // Final sign correction
    logic [2*WIDTH-1:0] prodMag, prodFinal;
    logic [WIDTH-1:0]   quotFinal, remFinal;

    assign prodMag   = {accHiReg, accLoReg};
    assign prodFinal = negQuotReg ? -prodMag : prodMag;
    assign quotFinal = negQuotReg ? -accLoReg : accLoReg;
    assign remFinal  = negRemReg ? -accHiReg : accHiReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            hiReg       <= '0;
            loReg       <= '0;
            accHiReg    <= '0;
            accLoReg    <= '0;
            magBReg     <= '0;
            isDivReg    <= 1'b0;
            negQuotReg  <= 1'b0;
            negRemReg   <= 1'b0;
            zeroDivReg  <= 1'b0;
            doneReg     <= 1'b0;
            dzReg       <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            hiReg       <= hiNext;
            loReg       <= loNext;
            accHiReg    <= accHiNext;
            accLoReg    <= accLoNext;
            magBReg     <= magBNext;
            isDivReg    <= isDivNext;
            negQuotReg  <= negQuotNext;
            negRemReg   <= negRemNext;
            zeroDivReg  <= zeroDivNext;
            doneReg     <= doneNext;
            dzReg       <= dzNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        cntNext     = cntReg;
        hiNext      = hiReg;
        loNext      = loReg;
        accHiNext   = accHiReg;
        accLoNext   = accLoReg;
        magBNext    = magBReg;
        isDivNext   = isDivReg;
        negQuotNext = negQuotReg;
        negRemNext  = negRemReg;
        zeroDivNext = zeroDivReg;
        doneNext    = 1'b0;
        dzNext      = 1'b0;

        case (stateReg)
            IDLE: begin
                if (Start) begin
                    isDivNext   = Op[1];
                    negQuotNext = signedOp && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
                    negRemNext  = signedOp && OperandA[WIDTH-1];
                    accHiNext   = '0;
                    accLoNext   = magA;
                    magBNext    = magB;
                    cntNext     = CW'(WIDTH - 1);
                    // A zero divisor skips the iterations and reports through FIX
                    if (Op[1] && (OperandB == '0)) begin
                        zeroDivNext = 1'b1;
                        stateNext   = FIX;
                    end else begin
                        zeroDivNext = 1'b0;
                        stateNext   = CALC;
                    end
                end else begin
                    if (WriteHi) begin
                        hiNext = WriteData;
                    end
                    if (WriteLo) begin
                        loNext = WriteData;
                    end
                end
            end

            CALC: begin
                if (isDivReg) begin
                    accHiNext = divHi;
                    accLoNext = divLo;
                end else begin
                    accHiNext = mulHi;
                    accLoNext = mulLo;
                end
                if (cntReg == '0) begin
                    stateNext = FIX;
                end else begin
                    cntNext = cntReg - 1'b1;
                end
            end

            FIX: begin
                stateNext = IDLE;
                doneNext  = 1'b1;
                if (zeroDivReg) begin
                    dzNext = 1'b1;
                end else if (isDivReg) begin
                    hiNext = remFinal;
                    loNext = quotFinal;
                end else begin
                    hiNext = prodFinal[2*WIDTH-1:WIDTH];
                    loNext = prodFinal[WIDTH-1:0];
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign Busy      = (stateReg != IDLE);
    assign Done      = doneReg;
    assign DivByZero = dzReg;
    assign Hi        = hiReg;
    assign Lo        = loReg;

endmodule
